// File: rtl/gradient_stream_stage.sv
// Gradient preprocessing stage: sign-extends, splits address into set/tag, flags direct triggers,
// and buffers beats behind a 2-entry output/skid pair. Optional counters under GSTREAM_STATS_EN.
module gradient_stream_stage #(
    parameter int DEPTH      = 256,
    parameter int NUM_WAYS   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int GRAD_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int THRESHOLD  = 1000,
    parameter int DROP_ZERO  = 0,
    localparam int NUM_SETS        = DEPTH / NUM_WAYS,
    localparam int SET_INDEX_WIDTH = $clog2(NUM_SETS),
    localparam int TAG_WIDTH       = ADDR_WIDTH - SET_INDEX_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_WIDTH-1:0]      in_addr,
    input  logic [GRAD_WIDTH-1:0]      in_grad,
    input  logic                       cfg_threshold_we,
    input  logic [ACC_WIDTH-1:0]       cfg_threshold,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_WIDTH-1:0]      out_addr,
    output logic [SET_INDEX_WIDTH-1:0] out_set_index,
    output logic [TAG_WIDTH-1:0]       out_tag,
    output logic [ACC_WIDTH-1:0]       out_grad_ext,
`ifdef GSTREAM_STATS_EN
    output logic [ACC_WIDTH-1:0]       stat_accepted,
    output logic [ACC_WIDTH-1:0]       stat_direct,
    output logic [ACC_WIDTH-1:0]       stat_dropped,
`endif
    output logic                       out_direct_trigger
);

    logic [ACC_WIDTH-1:0]  thr_q;
    logic                  skid_valid;
    logic [ADDR_WIDTH-1:0] skid_addr;
    logic [ACC_WIDTH-1:0]  skid_grad;
    logic                  skid_trig;

    logic [ACC_WIDTH-1:0]  grad_ext;
    logic [ACC_WIDTH-1:0]  grad_abs;
    logic [ACC_WIDTH-1:0]  thr_abs;
    logic                  trig;
    logic                  accept;
    logic                  drop;
    logic                  keep;
    logic                  out_fire;

    // Magnitudes are compared unsigned, so the most negative values need no special case.
    assign grad_ext = {{(ACC_WIDTH-GRAD_WIDTH){in_grad[GRAD_WIDTH-1]}}, in_grad};
    assign grad_abs = grad_ext[ACC_WIDTH-1] ? (-grad_ext) : grad_ext;
    assign thr_abs  = thr_q[ACC_WIDTH-1] ? (-thr_q) : thr_q;
    assign trig     = (grad_abs >= thr_abs);

    assign in_ready = ~skid_valid;
    assign accept   = in_valid && in_ready;
    assign drop     = (DROP_ZERO != 0) && (in_grad == '0);
    assign keep     = accept && !drop;
    assign out_fire = out_valid && out_ready;

    assign out_set_index = out_addr[SET_INDEX_WIDTH-1:0];
    assign out_tag       = out_addr[ADDR_WIDTH-1:SET_INDEX_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            thr_q              <= ACC_WIDTH'(THRESHOLD);
            out_valid          <= 1'b0;
            out_addr           <= '0;
            out_grad_ext       <= '0;
            out_direct_trigger <= 1'b0;
            skid_valid         <= 1'b0;
            skid_addr          <= '0;
            skid_grad          <= '0;
            skid_trig          <= 1'b0;
        end else begin
            if (cfg_threshold_we) thr_q <= cfg_threshold;
            // Accept is only possible while the skid is empty, so the first branch never sees keep.
            if (out_fire && skid_valid) begin
                out_addr           <= skid_addr;
                out_grad_ext       <= skid_grad;
                out_direct_trigger <= skid_trig;
                skid_valid         <= 1'b0;
            end else if (out_fire || !out_valid) begin
                out_valid <= keep;
                if (keep) begin
                    out_addr           <= in_addr;
                    out_grad_ext       <= grad_ext;
                    out_direct_trigger <= trig;
                end
            end else if (keep) begin
                skid_addr  <= in_addr;
                skid_grad  <= grad_ext;
                skid_trig  <= trig;
                skid_valid <= 1'b1;
            end
        end
    end

`ifdef GSTREAM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_accepted <= '0;
            stat_direct   <= '0;
            stat_dropped  <= '0;
        end else begin
            if (accept && stat_accepted != '1) stat_accepted <= stat_accepted + ACC_WIDTH'(1);
            if (keep && trig && stat_direct != '1) stat_direct <= stat_direct + ACC_WIDTH'(1);
            if (accept && drop && stat_dropped != '1) stat_dropped <= stat_dropped + ACC_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_gradient_stream_stage.sv
// Bench for gradient_stream_stage: default instance plus a DROP_ZERO=1 instance, queue-based scoreboards.
module tb_gradient_stream_stage;
    localparam int AW = 32;
    localparam int GW = 16;
    localparam int XW = 32;
    localparam int SW = 6;
    localparam int TW = AW - SW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_valid1 = 1'b0;
    logic          in_ready, in_ready1;
    logic [AW-1:0] in_addr = '0;
    logic [GW-1:0] in_grad = '0;
    logic          cfg_we = 1'b0;
    logic [XW-1:0] cfg_thr = '0;
    logic          out_valid, out_valid1;
    logic          out_ready = 1'b0, out_ready1 = 1'b1;
    logic [AW-1:0] out_addr, out_addr1;
    logic [SW-1:0] out_set_index, out_set_index1;
    logic [TW-1:0] out_tag, out_tag1;
    logic [XW-1:0] out_grad_ext, out_grad_ext1;
    logic          out_trig, out_trig1;
`ifdef GSTREAM_STATS_EN
    logic [XW-1:0] st_acc, st_dir, st_drp, st_acc1, st_dir1, st_drp1;
`endif

    int checks = 0;
    int errors = 0;
    int pops0 = 0;
    int stalls = 0;
    logic [64:0] exp_q[$];
    logic [64:0] exp1_q[$];

    always #5 clk = ~clk;

    gradient_stream_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_grad(in_grad), .cfg_threshold_we(cfg_we), .cfg_threshold(cfg_thr),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_set_index(out_set_index), .out_tag(out_tag), .out_grad_ext(out_grad_ext),
`ifdef GSTREAM_STATS_EN
        .stat_accepted(st_acc), .stat_direct(st_dir), .stat_dropped(st_drp),
`endif
        .out_direct_trigger(out_trig)
    );

    gradient_stream_stage #(.DROP_ZERO(1)) dut_drop (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_addr(in_addr), .in_grad(in_grad), .cfg_threshold_we(cfg_we), .cfg_threshold(cfg_thr),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_addr(out_addr1),
        .out_set_index(out_set_index1), .out_tag(out_tag1), .out_grad_ext(out_grad_ext1),
`ifdef GSTREAM_STATS_EN
        .stat_accepted(st_acc1), .stat_direct(st_dir1), .stat_dropped(st_drp1),
`endif
        .out_direct_trigger(out_trig1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [XW-1:0] sext(input logic [GW-1:0] g);
        return {{(XW-GW){g[GW-1]}}, g};
    endfunction

    // Scoreboard monitors: the head entry must be on the outputs whenever valid is high.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("out0_unexpected", 64'(out_addr), 64'hDEAD);
            end else begin
                chk("out0_addr", 64'(out_addr), 64'(exp_q[0][64:33]));
                chk("out0_grad", 64'(out_grad_ext), 64'(exp_q[0][32:1]));
                chk("out0_trig", 64'(out_trig), 64'(exp_q[0][0]));
                chk("out0_set", 64'(out_set_index), 64'(exp_q[0][33+SW-1:33]));
                chk("out0_tag", 64'(out_tag), 64'(exp_q[0][64:33+SW]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    pops0++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1) begin
            if (exp1_q.size() == 0) begin
                chk("out1_unexpected", 64'(out_grad_ext1), 64'hDEAD);
            end else begin
                chk("out1_addr", 64'(out_addr1), 64'(exp1_q[0][64:33]));
                chk("out1_grad", 64'(out_grad_ext1), 64'(exp1_q[0][32:1]));
                chk("out1_trig", 64'(out_trig1), 64'(exp1_q[0][0]));
                if (out_ready1) void'(exp1_q.pop_front());
            end
        end
    end

    task automatic send0(input logic [AW-1:0] a, input logic [GW-1:0] g, input logic t);
        int n;
        in_addr  = a;
        in_grad  = g;
        in_valid = 1'b1;
        n = 0;
        if (!in_ready) stalls++;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("send0_timeout", 64'(in_ready), 64'd1);
        end else begin
            exp_q.push_back({a, sext(g), t});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain0();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain0_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic write_thr(input logic [XW-1:0] v);
        cfg_thr = v;
        cfg_we  = 1'b1;
        @(posedge clk); #1;
        cfg_we  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [GW-1:0] g;
        logic [XW-1:0] ge;
        logic [XW-1:0] ga;
        int p0;
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_out_grad", 64'(out_grad_ext), 64'd0);
        chk("rst_out_trig", 64'(out_trig), 64'd0);
`ifdef GSTREAM_STATS_EN
        chk("rst_stat_acc", 64'(st_acc), 64'd0);
`endif

        // Basic beat with the most negative gradient
        out_ready = 1'b1;
        send0(32'h0000_0123, 16'h8000, 1'b1);
        chk("basic_valid", 64'(out_valid), 64'd1);
        chk("basic_set", 64'(out_set_index), 64'h23);
        chk("basic_tag", 64'(out_tag), 64'h4);
        chk("basic_grad", 64'(out_grad_ext), 64'hFFFF_8000);
        chk("basic_trig", 64'(out_trig), 64'd1);

        // Threshold edges, then a write in the same cycle as an accepted beat
        send0(32'h10, 16'd999, 1'b0);
        send0(32'h11, 16'd1000, 1'b1);
        send0(32'h12, 16'hFC18, 1'b1);
        cfg_thr = '0;
        cfg_we  = 1'b1;
        send0(32'h13, 16'd5, 1'b0);
        cfg_we  = 1'b0;
        send0(32'h14, 16'd0, 1'b1);
        // Most negative threshold: |thr| = 2^31, no gradient reaches it
        write_thr(32'h8000_0000);
        send0(32'h15, 16'h8000, 1'b0);
        write_thr(32'hFFFF_FC18);
        send0(32'h16, 16'd1000, 1'b1);
        write_thr(32'd1000);
        drain0();

        // Full throughput: 100 beats with out_ready held high
        stalls = 0;
        p0 = pops0;
        for (int i = 0; i < 100; i++) begin
            g  = GW'(i * 23 - 1150);
            ge = sext(g);
            ga = ge[XW-1] ? -ge : ge;
            send0(32'h1000_0000 + 32'(i * 37), g, ga >= 32'd1000);
        end
        @(posedge clk); #1;
        chk("tput_outputs", 64'(pops0 - p0), 64'd100);
        chk("tput_stalls", 64'(stalls), 64'd0);
        chk("tput_idle", 64'(out_valid), 64'd0);

        // Backpressure: A and B fill both registers, C waits
        out_ready = 1'b0;
        send0(32'hA0, 16'd1, 1'b0);
        send0(32'hB0, 16'd2, 1'b0);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        in_addr  = 32'hC0;
        in_grad  = 16'd3;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_still_full", 64'(in_ready), 64'd0);
        chk("bp_hold_a", 64'(out_addr), 64'hA0);
        out_ready = 1'b1;
        send0(32'hC0, 16'd3, 1'b0);
        send0(32'hD0, 16'hFFFF, 1'b0);
        drain0();

        // New threshold takes effect, then reset with the skid full restores it
        write_thr(32'd500);
        send0(32'h20, 16'd999, 1'b1);
        drain0();
        out_ready = 1'b0;
        send0(32'h30, 16'd7, 1'b0);
        send0(32'h31, 16'd8, 1'b0);
        chk("stall_full", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
`ifdef GSTREAM_STATS_EN
        chk("mid_rst_stat_acc", 64'(st_acc), 64'd0);
        chk("mid_rst_stat_dir", 64'(st_dir), 64'd0);
`endif
        out_ready = 1'b1;
        send0(32'h40, 16'd999, 1'b0);
        drain0();

        // Zero-drop instance: grads 3,0,0,-7
        for (int i = 0; i < 4; i++) begin
            g = (i == 0) ? 16'd3 : (i == 3) ? 16'hFFF9 : 16'd0;
            in_addr   = 32'h50 + 32'(i);
            in_grad   = g;
            in_valid1 = 1'b1;
            chk("drop_in_ready", 64'(in_ready1), 64'd1);
            if (g != 0) exp1_q.push_back({32'h50 + 32'(i), sext(g), 1'b0});
            @(posedge clk); #1;
        end
        in_valid1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("drop_left", 64'(exp1_q.size()), 64'd0);
        chk("drop_idle", 64'(out_valid1), 64'd0);
`ifdef GSTREAM_STATS_EN
        chk("drop_stat_acc", 64'(st_acc1), 64'd4);
        chk("drop_stat_drp", 64'(st_drp1), 64'd2);
        chk("drop_stat_dir", 64'(st_dir1), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gradient_stream_stage.md
Name: gradient_stream_stage

Overview:
- Registered, back-pressurable preprocessing stage in front of the set-associative accumulator.
- Sign-extends a GRAD_WIDTH gradient to ACC_WIDTH and splits the address into set index and tag.
- Flags direct-trigger beats against a runtime-programmable threshold and can drop zero gradients.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the accumulator can stall without losing data.

Parameters:
- DEPTH, 256: total accumulator entries.
- NUM_WAYS, 4: associativity. NUM_SETS = DEPTH/NUM_WAYS; SET_INDEX_WIDTH = $clog2(NUM_SETS). DEPTH and NUM_WAYS are powers of two.
- ADDR_WIDTH, 32: address width.
- GRAD_WIDTH, 16: input gradient width.
- ACC_WIDTH, 32: extended gradient width; must be >= GRAD_WIDTH+1.
- THRESHOLD, 1000: reset value of the threshold register (signed ACC_WIDTH).
- DROP_ZERO, 0: when 1, beats with gradient == 0 are consumed and never forwarded.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: stage can accept a beat.
- in_addr, input, ADDR_WIDTH: gradient address.
- in_grad, input, GRAD_WIDTH: signed gradient.
- cfg_threshold_we, input, 1: write strobe for the threshold register.
- cfg_threshold, input, ACC_WIDTH: signed threshold value.
- out_valid, output, 1: output beat valid.
- out_ready, input, 1: downstream accepts the beat.
- out_addr, output, ADDR_WIDTH: address passthrough.
- out_set_index, output, SET_INDEX_WIDTH: in_addr[SET_INDEX_WIDTH-1:0].
- out_tag, output, ADDR_WIDTH-SET_INDEX_WIDTH: in_addr[ADDR_WIDTH-1:SET_INDEX_WIDTH].
- out_grad_ext, output, ACC_WIDTH: sign-extended gradient.
- out_direct_trigger, output, 1: |grad| >= |threshold|.

Behaviour:
- Reset values: out_valid=0, all out_* data=0, in_ready=1, skid empty, threshold register=THRESHOLD, stats counters=0.
- Reset mid-transfer discards both buffered beats.
- Handshakes:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - out_valid is held and out_* data stays stable until the output transfer.
- Latency: an accepted beat is presented on out_* the next cycle if the output register is empty or draining that same cycle.
- Skid buffer:
  - If the output register holds a beat and out_ready=0, an accepted beat goes to the skid register.
  - in_ready = !skid_valid and is registered; it has no combinational path from out_ready.
  - When the output transfer happens with skid_valid=1, the skid moves to the output register and skid_valid clears.
  - Order is strictly preserved. Throughput is 1 beat/cycle with out_ready held high.
- Full/empty: both registers occupied means in_ready=0. A simultaneous output transfer frees the skid on the following cycle, never the same cycle.
- Arithmetic:
  - grad_ext = sign-extend(in_grad) to ACC_WIDTH.
  - |grad| is computed in ACC_WIDTH bits. It is exact for the most negative GRAD value (e.g. -32768 gives 32768), since ACC_WIDTH > GRAD_WIDTH.
  - |threshold| is treated as unsigned ACC_WIDTH bits, so the most negative ACC value gives 2^(ACC_WIDTH-1) without overflow.
  - direct_trigger = (unsigned)|grad| >= |threshold|. Threshold 0 makes every beat trigger.
- Classification is computed at input acceptance and stored with the beat.
- Threshold register:
  - Loaded on cfg_threshold_we at the clock edge.
  - Beats accepted in the same cycle as the write use the old value; beats accepted from the next cycle use the new value.
  - Beats already buffered are never reclassified.
- DROP_ZERO=1: a beat with in_grad==0 is accepted (in_ready behaves as normal) and discarded; it does not occupy either register.
- Simultaneous in accept, out transfer and cfg write in one cycle are all honoured independently.

Optional Feature:
- Macro GSTREAM_STATS_EN.
- When defined, adds three outputs, each ACC_WIDTH wide, saturating at all-ones and cleared by rst:
  - stat_accepted: incremented per input transfer.
  - stat_direct: incremented per accepted beat with direct_trigger=1, counting dropped beats excluded.
  - stat_dropped: incremented per zero-drop.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Basic beat: rst, then in_valid=1, addr=0x0000_0123, grad=16'sh8000, out_ready=1, defaults (64 sets, SET_INDEX_WIDTH=6) -> next cycle out_valid=1, out_set_index=0x23, out_tag=0x4, out_grad_ext=32'hFFFF_8000, out_direct_trigger=1.
- Threshold edge: grad=999 -> trigger 0; grad=1000 -> 1; grad=-1000 -> 1. Then cfg write 0 in the same cycle as grad=5 is accepted -> that beat trigger 0; the next beat grad=0 -> trigger 1.
- Backpressure: stream beats A,B,C,D with out_ready=0 -> only A and B accepted, in_ready=0 from cycle 3. Raise out_ready -> outputs A,B,C,D in order, no loss or duplication, data stable while stalled.
- Full throughput: 100 beats, in_valid and out_ready both held high -> 100 outputs in 101 cycles, in_ready never drops.
- DROP_ZERO=1: grads 3,0,0,-7 -> outputs only 3 and -7. With GSTREAM_STATS_EN: accepted=4, dropped=2, direct=0.
- Reset mid-stall: skid full, assert rst for one cycle -> out_valid=0, in_ready=1, threshold back to 1000, counters 0.
